// File: rtl/ps2_tx_shifter.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, 11-bit frame shifted on device falls, ACK check.
// Optional watchdog on a silent device is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_tx_shifter #(
    parameter int INHIBIT_CYCLES = 1300,
    parameter int SETUP_CYCLES   = 16
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 250000
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write,
    input  logic [7:0] tx_scancode,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       timeout
);

    // Handshake: write is a one-cycle strobe that is taken only while busy is low;
    // busy is the inverse of ready, and a strobe seen while busy is dropped.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        START   = 3'd2,
        SEND    = 3'd3,
        ACK     = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INHIBIT_LOAD = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] SETUP_LOAD   = CW'(SETUP_CYCLES - 1);

    state_t     state, state_next;
    logic [CW-1:0] cnt_q, cnt_next;
    logic [3:0] bit_q, bit_next;
    logic [7:0] byte_q, byte_next;
    logic       parity_q, parity_next;
    logic       clock_oe_next, data_oe_next;
    logic       busy_next, done_next, ack_next;

    logic [1:0] clk_sync, data_sync;
    logic       clk_prev;
    logic       clk_s, data_s, fall;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;

    // Synchronisers start at the idle (high) level so reset never fabricates a fall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clock_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_s;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYCLES);

    logic [WW-1:0] wd_q, wd_next;
    logic          timeout_q, timeout_next;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            cnt_q        <= '0;
            bit_q        <= 4'd0;
            byte_q       <= 8'd0;
            parity_q     <= 1'b0;
            ps2_clock_oe <= 1'b0;
            ps2_data_oe  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ack_error    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q         <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            cnt_q        <= cnt_next;
            bit_q        <= bit_next;
            byte_q       <= byte_next;
            parity_q     <= parity_next;
            ps2_clock_oe <= clock_oe_next;
            ps2_data_oe  <= data_oe_next;
            busy         <= busy_next;
            done         <= done_next;
            ack_error    <= ack_next;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q         <= wd_next;
            timeout_q    <= timeout_next;
`endif
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt_q;
        bit_next      = bit_q;
        byte_next     = byte_q;
        parity_next   = parity_q;
        clock_oe_next = ps2_clock_oe;
        data_oe_next  = ps2_data_oe;
        busy_next     = busy;
        done_next     = 1'b0;
        ack_next      = ack_error;
`ifdef PS2_TX_TIMEOUT_EN
        wd_next       = wd_q;
        timeout_next  = timeout_q;
`endif

        case (state)
            IDLE: begin
                clock_oe_next = 1'b0;
                data_oe_next  = 1'b0;
                busy_next     = 1'b0;
                if (write) begin
                    byte_next     = tx_scancode;
                    parity_next   = ~^tx_scancode;
                    ack_next      = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
                    timeout_next  = 1'b0;
`endif
                    cnt_next      = INHIBIT_LOAD;
                    bit_next      = 4'd0;
                    clock_oe_next = 1'b1;
                    busy_next     = 1'b1;
                    state_next    = INHIBIT;
                end
            end

            INHIBIT: begin
                if (cnt_q == '0) begin
                    data_oe_next = 1'b1;
                    cnt_next     = SETUP_LOAD;
                    state_next   = START;
                end else begin
                    cnt_next = cnt_q - CW'(1);
                end
            end

            START: begin
                if (cnt_q == '0) begin
                    clock_oe_next = 1'b0;
                    bit_next      = 4'd0;
`ifdef PS2_TX_TIMEOUT_EN
                    wd_next       = WD_LOAD;
`endif
                    state_next    = SEND;
                end else begin
                    cnt_next = cnt_q - CW'(1);
                end
            end

            // Fall n (bit_q = n-1) presents data bit n-1, then parity, then releases for stop.
            SEND: begin
                if (fall) begin
                    if (bit_q < 4'd8) begin
                        data_oe_next = ~byte_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        data_oe_next = ~parity_q;
                    end else begin
                        data_oe_next = 1'b0;
                        state_next   = ACK;
                    end
                    if (bit_q != 4'd10) begin
                        bit_next = bit_q + 4'd1;
                    end
                end
            end

            ACK: begin
                if (fall) begin
                    ack_next   = data_s;
                    state_next = DONE;
                end
            end

            DONE: begin
                if (clk_s && data_s) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end

            default: begin
                clock_oe_next = 1'b0;
                data_oe_next  = 1'b0;
                busy_next     = 1'b0;
                state_next    = IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        if (state == SEND || state == ACK || state == DONE) begin
            if (fall) begin
                wd_next = WD_LOAD;
            end else if (wd_q <= WW'(1)) begin
                wd_next       = '0;
                clock_oe_next = 1'b0;
                data_oe_next  = 1'b0;
                busy_next     = 1'b0;
                done_next     = 1'b1;
                ack_next      = 1'b1;
                timeout_next  = 1'b1;
                state_next    = IDLE;
            end else begin
                wd_next = wd_q - WW'(1);
            end
        end
`endif
    end

endmodule

// File: tb/tb_ps2_tx_shifter.sv
// Bench for ps2_tx_shifter: cycle-level host-phase model, scoreboard of expected 11-bit frames,
// and a PS/2 device model that clocks the frame out and ACKs or NACKs.
module tb_ps2_tx_shifter;

    localparam int INH   = 1300;
    localparam int SET   = 16;
    localparam int REL_K = INH + SET + 1;
`ifdef PS2_TX_TIMEOUT_EN
    localparam int TO    = 1000;
`endif

    localparam int M_IDLE = 0;
    localparam int M_HOST = 1;
    localparam int M_DEV  = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       write = 1'b0;
    logic [7:0] tx_scancode = 8'd0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clock_in, ps2_data_in;
    logic       ps2_clock_oe, ps2_data_oe, busy, done, ack_error, timeout;

    // Open-drain lines: low if either side pulls.
    assign ps2_clock_in = dev_clk & ~ps2_clock_oe;
    assign ps2_data_in  = dev_data & ~ps2_data_oe;

    always #5 clock = ~clock;

    ps2_tx_shifter #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES(SET)
`ifdef PS2_TX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .write(write),
        .tx_scancode(tx_scancode),
        .ps2_clock_in(ps2_clock_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clock_oe(ps2_clock_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .done(done),
        .ack_error(ack_error),
        .timeout(timeout)
    );

    int          total = 0;
    int          bad = 0;
    logic [10:0] exp_q[$];
    int          m_state = M_IDLE;
    int          m_k = 0;
    logic        m_exp_ack = 1'b0;
    logic        m_to = 1'b0;
    logic        pend_nack = 1'b0;
    logic        pend_to = 1'b0;
    bit          mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Frame as the device sees it on the wire, bit 0 first: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Model: a strobe is taken only when the modelled transmitter is idle.
    always @(posedge clock) begin
        if (mon_on && reset && write && m_state == M_IDLE) begin
            m_state = M_HOST;
            m_k = 0;
            exp_q.push_back(frame_of(tx_scancode));
            m_exp_ack = pend_nack;
            m_to = pend_to;
        end
    end

    // Compare process: checks outputs every cycle against the phase model.
    always @(negedge clock) begin
        if (mon_on) begin
            case (m_state)
                M_HOST: begin
                    m_k++;
                    check("host_clock_oe", ps2_clock_oe, (m_k <= INH + SET) ? 1 : 0);
                    check("host_data_oe", ps2_data_oe, (m_k > INH) ? 1 : 0);
                    check("host_busy", busy, 1);
                    check("host_done", done, 0);
                    check("host_ack_clr", ack_error, 0);
                    check("host_to_clr", timeout, 0);
                    if (m_k == REL_K) m_state = M_DEV;
                end
                M_DEV: begin
                    m_k++;
                    check("dev_clock_oe", ps2_clock_oe, 0);
                    if (done) begin
                        check("done_busy", busy, 0);
                        check("done_data_oe", ps2_data_oe, 0);
                        check("done_ack_error", ack_error, m_exp_ack);
                        check("done_timeout", timeout, m_to);
`ifdef PS2_TX_TIMEOUT_EN
                        if (m_to) check("timeout_cycle", m_k, REL_K + TO);
`endif
                        m_state = M_IDLE;
                    end else begin
                        check("dev_busy", busy, 1);
                        check("dev_timeout", timeout, 0);
                    end
                end
                default: begin
                    check("idle_busy", busy, 0);
                    check("idle_done", done, 0);
                    check("idle_clock_oe", ps2_clock_oe, 0);
                    check("idle_data_oe", ps2_data_oe, 0);
                    check("idle_ack_error", ack_error, m_exp_ack);
                    check("idle_timeout", timeout, m_to);
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clock);
        write = 1'b1;
        tx_scancode = b;
        @(negedge clock);
        write = 1'b0;
        tx_scancode = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_release(output bit ok);
        int t;
        t = 0;
        while (ps2_clock_oe !== 1'b0 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        ok = (ps2_clock_oe === 1'b0);
        if (!ok) fail("release_wait");
    endtask

    // One device clock: low phase, sample on the rising edge, high phase.
    task automatic dev_clock(input int h, output logic s);
        dev_clk = 1'b0;
        tick(h);
        s = ps2_data_in;
        dev_clk = 1'b1;
        tick(h);
    endtask

    task automatic device_run(input int h, input logic nack, output logic [10:0] fr);
        bit   ok;
        logic s;
        fr = '0;
        wait_release(ok);
        if (ok) begin
            tick(h);
            fr[0] = ps2_data_in;
            for (int i = 1; i <= 10; i++) begin
                dev_clock(h, s);
                fr[i] = s;
            end
            dev_data = nack;
            tick(4);
            dev_clock(h, s);
            dev_data = 1'b1;
        end
    endtask

    task automatic score(input logic [10:0] fr);
        if (exp_q.size() == 0) fail("exp_q_empty");
        else check("frame", fr, exp_q.pop_front());
    endtask

    task automatic wait_idle(input int bound);
        int t;
        t = 0;
        while (m_state != M_IDLE && t < bound) begin
            tick(1);
            t++;
        end
        if (m_state != M_IDLE) fail("done_wait");
    endtask

    task automatic send(input logic [7:0] b, input logic nack, input int h, output logic [10:0] fr);
        pend_nack = nack;
        pend_to = 1'b0;
        write_byte(b);
        device_run(h, nack, fr);
        score(fr);
        wait_idle(400);
    endtask

    initial begin
        logic [10:0] fr;
        bit          ok;
        logic        s;

        reset = 1'b0;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clock_oe", ps2_clock_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_ack_error", ack_error, 0);
        check("rst_timeout", timeout, 0);
        reset = 1'b1;
        m_state = M_IDLE;
        mon_on = 1'b1;
        tick(3);

        send(8'hED, 1'b0, 20, fr);
        check("frame_ED", fr, 11'h7DA);
        send(8'h00, 1'b0, 16, fr);
        check("parity_00", fr[9], 1);
        send(8'hFF, 1'b0, 16, fr);
        check("parity_FF", fr[9], 1);
        send(8'h01, 1'b0, 16, fr);
        check("parity_01", fr[9], 0);
        check("frame_01", fr, 11'h402);

        send(8'h5A, 1'b1, 18, fr);
        tick(1);
        check("nack_sticky", ack_error, 1);
        send(8'h3C, 1'b0, 18, fr);
        check("nack_cleared", ack_error, 0);

        // Strobe while busy, mid-frame: must leave 0xED and a single done pulse.
        pend_nack = 1'b0;
        pend_to = 1'b0;
        write_byte(8'hED);
        fork
            device_run(20, 1'b0, fr);
            begin
                tick(REL_K + 60);
                write = 1'b1;
                tx_scancode = 8'hF4;
                tick(1);
                write = 1'b0;
            end
        join
        score(fr);
        check("busy_write_frame", fr, 11'h7DA);
        wait_idle(400);

        for (int r = 0; r < 6; r++) begin
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(12, 30), fr);
            tick($urandom_range(0, 10));
        end

        // Reset in the middle of SEND.
        pend_nack = 1'b0;
        pend_to = 1'b0;
        write_byte(8'h96);
        wait_release(ok);
        tick(20);
        for (int i = 0; i < 3; i++) dev_clock(20, s);
        mon_on = 1'b0;
        reset = 1'b0;
        tick(1);
        check("midrst_clock_oe", ps2_clock_oe, 0);
        check("midrst_data_oe", ps2_data_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        tick(1);
        check("midrst_done2", done, 0);
        reset = 1'b1;
        exp_q.delete();
        m_state = M_IDLE;
        m_exp_ack = 1'b0;
        m_to = 1'b0;
        tick(1);
        check("postrst_done", done, 0);
        mon_on = 1'b1;
        tick(3);
        send(8'hC3, 1'b0, 15, fr);

`ifdef PS2_TX_TIMEOUT_EN
        pend_nack = 1'b1;
        pend_to = 1'b1;
        write_byte(8'h42);
        wait_idle(3000);
        exp_q.delete();
        tick(1);
        check("to_flag", timeout, 1);
        check("to_ack_error", ack_error, 1);
        send(8'h24, 1'b0, 16, fr);
        check("to_cleared", timeout, 0);
`endif

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        fail("global_timeout");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_tx_shifter.md
Name: ps2_tx_shifter

Overview:
Host-to-device PS/2 transmitter. It is the send-side counterpart of ps2_rx_shifter and is used to send commands to the keyboard, for example 0xED for set LEDs or 0xFF for reset. The CPU loads one byte per write strobe. The block performs the PS/2 request-to-send sequence, shifts out the frame (8 data bits, odd parity, stop) on device-generated clock edges, then reports the device's ACK. The board top maps its strobe and status into the 0x02 I/O page and drives the ps2a_clock and ps2a_data pins open-drain from the two _oe outputs.

Parameters:
INHIBIT_CYCLES, 1300, clock cycles the ps2 clock is held low before the request (≥100 us at 12.5 MHz).
SETUP_CYCLES, 16, clock cycles data is held low together with clock before clock is released.
TIMEOUT_CYCLES, 250000, cycles without a device falling edge before abort (PS2_TX_TIMEOUT_EN only).

Ports:
clock  input  1  CPU clock; all logic on its rising edge.
reset  input  1  synchronous, active-low reset.
write  input  1  one-cycle load strobe (write & cs from the decoder).
tx_scancode  input  8  byte to send; sampled on the write cycle.
ps2_clock_in  input  1  raw ps2 clock pin level (asynchronous).
ps2_data_in  input  1  raw ps2 data pin level (asynchronous).
ps2_clock_oe  output  1  1 = drive ps2 clock low, 0 = release.
ps2_data_oe  output  1  1 = drive ps2 data low, 0 = release.
busy  output  1  transfer in progress; the receive path ignores edges while this is high.
done  output  1  one-cycle pulse when a transfer ends (success, NACK or timeout).
ack_error  output  1  sticky: the device did not pull data low on the 11th edge. Cleared by the next accepted write.
timeout  output  1  sticky timeout flag. Cleared by the next accepted write.

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; all outputs 0; both lines released; bit counter 0.
- Input conditioning: each pin passes through a 2-flop synchroniser. fall = (previous synced clock==1 && synced clock==0), which is 3 cycles after the pin edge. Data is sampled from its synchroniser on the cycle that fall is high.
- Accept: a write in IDLE latches tx_scancode, computes parity = ~^tx_scancode, clears ack_error and timeout, and moves to INHIBIT. busy=1 and ps2_clock_oe=1 from the next cycle. A write while busy is ignored, with no effect on state or flags.
- INHIBIT: clock_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to START.
- START: clock_oe=1, data_oe=1 (start bit 0) for SETUP_CYCLES cycles. Then clock_oe=0 and go to SEND, with bit index 0 and data_oe still 1.
- SEND: each fall advances the frame. Fall n=1..8 sets data_oe = ~byte[n-1] (LSB first). Fall 9 sets data_oe = ~parity. Fall 10 sets data_oe=0 (stop bit, line released). Then go to ACK.
- ACK: on the next fall, ack_error = synced data level (0 = ACK received, so ack_error=0). Go to DONE.
- DONE: wait until synced ps2 clock==1 and synced data==1 (device idle). Then pulse done for one cycle, set busy=0, return to IDLE. Lines are released throughout.
- clock_oe and data_oe are registered outputs; they are never both released-then-driven in one cycle except as listed above.
- Falls seen in IDLE, INHIBIT or START are ignored. In INHIBIT and START they are self-inflicted by the host pulling clock low.
- Counters saturate and never wrap. The bit index is 4 bits and values above 10 are unreachable.
- Reset mid-transfer releases both lines at that edge and does not pulse done.

Optional Feature:
PS2_TX_TIMEOUT_EN:
- Defined: a watchdog reloads to TIMEOUT_CYCLES on entering SEND and on every fall in SEND, ACK or DONE. If it reaches 0, the block releases both lines, sets timeout=1, sets ack_error=1, pulses done and returns to IDLE.
- Undefined: no watchdog logic; the timeout output is tied to 0; a silent device leaves busy high until reset.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1. Required: busy=0, done=0, clock_oe=0, data_oe=0, ack_error=0, timeout=0.
- Send 0xED with a device model that ACKs: clock_oe=1 for exactly 1300 cycles, then data_oe=1 and clock_oe=1 for 16 cycles. The device samples bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1. Device ACKs → done pulses once, ack_error=0, busy=0.
- Send 0x00: the sampled parity bit is 1. Send 0xFF: the sampled parity bit is 1. Send 0x01: the sampled parity bit is 0.
- Device holds data high on the 11th clock (NACK) → done pulses, ack_error=1. The next write clears ack_error.
- Write 0xF4 while busy, during SEND of 0xED: the frame still carries 0xED and only one done pulse occurs.
- With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES=1000, the device never clocks. Required: 1000 cycles after clock release, timeout=1, ack_error=1, done pulses, both oe=0. Separately, reset mid-SEND releases both lines on that edge with no done pulse.
